// File: rtl/mod_counter.sv
// Prescaled up/down counter: wrap, saturate and one-shot modes, sticky flags.
// Latency: count, tc and flags update on the edge after an enabled tick; load takes one edge.
// Backpressure: none; enable gates the prescaler and load overrides everything except reset.
module mod_counter #(
  parameter int counter_size  = 8,
  parameter int prescale_size = 4
) (
  input  logic                     clk,
  input  logic                     res_n,
  input  logic                     enable,
  input  logic                     load,
  input  logic                     up_down,
  input  logic [1:0]               mode,
  input  logic [counter_size-1:0]  limit,
  input  logic [prescale_size-1:0] prescale,
  input  logic [counter_size-1:0]  cnt_in,
  input  logic                     clear_flags,
  output logic [counter_size-1:0]  cnt_out,
  output logic                     tc,
  output logic                     overflow,
  output logic                     underflow,
  output logic                     done
);

  localparam logic [counter_size-1:0]  CNT_ONE = counter_size'(1);
  localparam logic [prescale_size-1:0] PRE_ONE = prescale_size'(1);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  state_t                   r_state;
  logic [counter_size-1:0]  r_cnt;
  logic [prescale_size-1:0] r_pre;
  logic                     r_tc;
  logic                     r_ovf;
  logic                     r_unf;
  logic                     r_done;

  logic                     w_running;
  logic                     w_pre_hit;
  logic                     w_tick;
  logic                     w_up_term;
  logic                     w_dn_term;
  logic                     w_term;
  logic                     w_wrap;
  logic                     w_oneshot;
  logic [counter_size-1:0]  w_cnt_next;

  // Mode 11 is deliberately folded into wrap behaviour.
  assign w_wrap    = (mode == 2'b00) || (mode == 2'b11);
  assign w_oneshot = (mode == 2'b10);

  // Ticks are suppressed by load and while parked in DONE.
  assign w_running = (r_state == ST_RUN);
  assign w_pre_hit = (r_pre == prescale);
  assign w_tick    = enable & w_running & w_pre_hit & ~load;

  // Up terminal uses >= so a count loaded above limit still terminates.
  assign w_up_term = w_tick &  up_down & (r_cnt >= limit);
  assign w_dn_term = w_tick & ~up_down & (r_cnt == '0);
  assign w_term    = w_up_term | w_dn_term;

  // Next count value for a tick in the current direction and mode.
  always_comb begin
    w_cnt_next = r_cnt;
    if (w_tick) begin
      if (up_down) begin
        if (r_cnt < limit) begin
          w_cnt_next = r_cnt + CNT_ONE;
        end else if (w_wrap) begin
          w_cnt_next = '0;
        end else begin
          w_cnt_next = limit;
        end
      end else begin
        if (r_cnt != '0) begin
          w_cnt_next = r_cnt - CNT_ONE;
        end else if (w_wrap) begin
          w_cnt_next = limit;
        end else begin
          w_cnt_next = '0;
        end
      end
    end
  end

  // Prescaler: advances on enabled cycles in RUN, restarts on tick or load.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_pre <= '0;
    end else if (load) begin
      r_pre <= '0;
    end else if (enable && w_running) begin
      r_pre <= w_pre_hit ? '0 : (r_pre + PRE_ONE);
    end
  end

  // Count register: load wins over any tick.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= cnt_in;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

  // RUN/DONE state machine with registered tc pulse and done level.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_state <= ST_RUN;
      r_tc    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_tc <= w_term;
      if (load) begin
        r_state <= ST_RUN;
        r_done  <= 1'b0;
      end else if (w_term && w_oneshot) begin
        r_state <= ST_DONE;
        r_done  <= 1'b1;
      end
    end
  end

  // Sticky flags: a terminal event on the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (w_up_term) begin
        r_ovf <= 1'b1;
      end else if (clear_flags) begin
        r_ovf <= 1'b0;
      end
      if (w_dn_term) begin
        r_unf <= 1'b1;
      end else if (clear_flags) begin
        r_unf <= 1'b0;
      end
    end
  end

  assign cnt_out   = r_cnt;
  assign tc        = r_tc;
  assign overflow  = r_ovf;
  assign underflow = r_unf;
  assign done      = r_done;

endmodule

// File: tb/tb_mod_counter.sv
// Directed bench for mod_counter: expected outputs are queued per cycle and
// checked by an independent monitor on the falling clock edge.
module tb_mod_counter;

  logic       clk;
  logic       res_n;
  logic       enable;
  logic       load;
  logic       up_down;
  logic [1:0] mode;
  logic [7:0] limit;
  logic [3:0] prescale;
  logic [7:0] cnt_in;
  logic       clear_flags;
  logic [7:0] cnt_out;
  logic       tc;
  logic       overflow;
  logic       underflow;
  logic       done;

  int n_cmp;
  int n_bad;
  int n_step;

  // {cnt, tc, ovf, unf, done}
  logic [11:0] exp_q[$];
  int          id_q[$];

  mod_counter #(
    .counter_size (8),
    .prescale_size(4)
  ) dut (
    .clk        (clk),
    .res_n      (res_n),
    .enable     (enable),
    .load       (load),
    .up_down    (up_down),
    .mode       (mode),
    .limit      (limit),
    .prescale   (prescale),
    .cnt_in     (cnt_in),
    .clear_flags(clear_flags),
    .cnt_out    (cnt_out),
    .tc         (tc),
    .overflow   (overflow),
    .underflow  (underflow),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one queued expectation per clock, sampled away from the rising edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [11:0] e;
      logic [11:0] a;
      int          id;
      e  = exp_q.pop_front();
      id = id_q.pop_front();
      a  = {cnt_out, tc, overflow, underflow, done};
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL step%0d: got cnt=%0d tc=%b ovf=%b unf=%b done=%b, want cnt=%0d tc=%b ovf=%b unf=%b done=%b",
                 id, a[11:4], a[3], a[2], a[1], a[0], e[11:4], e[3], e[2], e[1], e[0]);
      end
    end
  end

  // Queue the outputs expected after the next rising edge, then advance one cycle.
  task automatic step(input logic [7:0] c, input logic t, input logic o,
                      input logic u, input logic d);
    exp_q.push_back({c, t, o, u, d});
    id_q.push_back(n_step);
    n_step++;
    @(negedge clk);
    #1;
  endtask

  // Immediate check that every output is in its reset state.
  task automatic check_zero(input string name);
    logic [11:0] a;
    a = {cnt_out, tc, overflow, underflow, done};
    n_cmp++;
    if (a !== 12'h000) begin
      n_bad++;
      $display("FAIL %s: got cnt=%0d tc=%b ovf=%b unf=%b done=%b, want all zero",
               name, cnt_out, tc, overflow, underflow, done);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    n_cmp = 0; n_bad = 0; n_step = 0;
    res_n = 1'b0; enable = 1'b0; load = 1'b0; up_down = 1'b1; mode = 2'b00;
    limit = 8'd0; prescale = 4'd0; cnt_in = 8'd0; clear_flags = 1'b0;

    @(negedge clk);
    #1;
    check_zero("reset_state");
    res_n = 1'b1;

    // Wrap up to limit 5, every enabled cycle ticks.
    enable = 1'b1; mode = 2'b00; up_down = 1'b1; limit = 8'd5; prescale = 4'd0;
    step(8'd1, 0, 0, 0, 0);
    step(8'd2, 0, 0, 0, 0);
    step(8'd3, 0, 0, 0, 0);
    step(8'd4, 0, 0, 0, 0);
    step(8'd5, 0, 0, 0, 0);
    step(8'd0, 1, 1, 0, 0);
    step(8'd1, 0, 1, 0, 0);
    enable = 1'b0; clear_flags = 1'b1;
    step(8'd1, 0, 0, 0, 0);
    clear_flags = 1'b0;

    // Prescale 2, down from 1, wrap to limit 3, then freeze mid-prescale.
    prescale = 4'd2; limit = 8'd3; up_down = 1'b0; enable = 1'b1;
    load = 1'b1; cnt_in = 8'd1;
    step(8'd1, 0, 0, 0, 0);
    load = 1'b0;
    step(8'd1, 0, 0, 0, 0);
    step(8'd1, 0, 0, 0, 0);
    step(8'd0, 0, 0, 0, 0);
    step(8'd0, 0, 0, 0, 0);
    step(8'd0, 0, 0, 0, 0);
    step(8'd3, 1, 0, 1, 0);
    step(8'd3, 0, 0, 1, 0);
    enable = 1'b0;
    for (int i = 0; i < 4; i++) step(8'd3, 0, 0, 1, 0);
    enable = 1'b1;
    step(8'd3, 0, 0, 1, 0);
    step(8'd2, 0, 0, 1, 0);
    enable = 1'b0; clear_flags = 1'b1;
    step(8'd2, 0, 0, 0, 0);
    clear_flags = 1'b0;

    // Saturate at 200, repeated terminal pulses, set beats clear.
    mode = 2'b01; up_down = 1'b1; limit = 8'd200; prescale = 4'd0; enable = 1'b1;
    load = 1'b1; cnt_in = 8'd198;
    step(8'd198, 0, 0, 0, 0);
    load = 1'b0;
    step(8'd199, 0, 0, 0, 0);
    step(8'd200, 0, 0, 0, 0);
    step(8'd200, 1, 1, 0, 0);
    step(8'd200, 1, 1, 0, 0);
    clear_flags = 1'b1;
    step(8'd200, 1, 1, 0, 0);
    enable = 1'b0;
    step(8'd200, 0, 0, 0, 0);
    clear_flags = 1'b0;

    // One-shot down from 2, DONE survives a mode change, load releases it.
    mode = 2'b10; up_down = 1'b0; limit = 8'd9; enable = 1'b1;
    load = 1'b1; cnt_in = 8'd2;
    step(8'd2, 0, 0, 0, 0);
    load = 1'b0;
    step(8'd1, 0, 0, 0, 0);
    step(8'd0, 0, 0, 0, 0);
    step(8'd0, 1, 0, 1, 1);
    step(8'd0, 0, 0, 1, 1);
    mode = 2'b00;
    step(8'd0, 0, 0, 1, 1);
    load = 1'b1; cnt_in = 8'd7;
    step(8'd7, 0, 0, 1, 0);
    load = 1'b0;
    step(8'd6, 0, 0, 1, 0);
    enable = 1'b0; clear_flags = 1'b1;
    step(8'd6, 0, 0, 0, 0);
    clear_flags = 1'b0;

    // Load beats a terminal tick; limit 0 terminates every tick; down above limit.
    mode = 2'b00; up_down = 1'b1; limit = 8'd5; enable = 1'b1;
    load = 1'b1; cnt_in = 8'd5;
    step(8'd5, 0, 0, 0, 0);
    cnt_in = 8'd2;
    step(8'd2, 0, 0, 0, 0);
    load = 1'b0; limit = 8'd0;
    step(8'd0, 1, 1, 0, 0);
    step(8'd0, 1, 1, 0, 0);
    up_down = 1'b0; limit = 8'd3; load = 1'b1; cnt_in = 8'd7;
    step(8'd7, 0, 1, 0, 0);
    load = 1'b0;
    step(8'd6, 0, 1, 0, 0);

    // Reach DONE at 0x7F, then reset asynchronously between edges.
    mode = 2'b10; up_down = 1'b1; limit = 8'd127; clear_flags = 1'b1;
    load = 1'b1; cnt_in = 8'd126;
    step(8'd126, 0, 0, 0, 0);
    load = 1'b0; clear_flags = 1'b0;
    step(8'd127, 0, 0, 0, 0);
    step(8'd127, 1, 1, 0, 1);
    step(8'd127, 0, 1, 0, 1);
    #2;
    res_n = 1'b0;
    #1;
    check_zero("async_reset_immediate");
    @(negedge clk);
    #1;
    check_zero("async_reset_held");
    mode = 2'b00; limit = 8'd5; up_down = 1'b1; enable = 1'b1;
    res_n = 1'b1;
    step(8'd1, 0, 0, 0, 0);
    step(8'd2, 0, 0, 0, 0);

    // Drain with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mod_counter.md
MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 The block SHALL have parameter counter_size, default 8, giving the counter width in bits (minimum 2).
REQ-002 The block SHALL have parameter prescale_size, default 4, giving the prescaler width in bits (minimum 1).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port res_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port enable, input, 1 bit: advances the prescaler while 1.
REQ-006 The block SHALL have port load, input, 1 bit: synchronous load of cnt_in.
REQ-007 The block SHALL have port up_down, input, 1 bit: count direction, 1 = up, 0 = down.
REQ-008 The block SHALL have port mode, input, 2 bits: 00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap.
REQ-009 The block SHALL have port limit, input, counter_size bits: the terminal (maximum) count value.
REQ-010 The block SHALL have port prescale, input, prescale_size bits: one count tick per prescale+1 enabled cycles.
REQ-011 The block SHALL have port cnt_in, input, counter_size bits: the load value.
REQ-012 The block SHALL have port clear_flags, input, 1 bit: synchronous clear of overflow and underflow.
REQ-013 The block SHALL have port cnt_out, output, counter_size bits: the registered count.
REQ-014 The block SHALL have port tc, output, 1 bit: registered one-cycle pulse marking a terminal event.
REQ-015 The block SHALL have port overflow, output, 1 bit: sticky flag, set on an up-direction terminal event.
REQ-016 The block SHALL have port underflow, output, 1 bit: sticky flag, set on a down-direction terminal event.
REQ-017 The block SHALL have port done, output, 1 bit: high while the one-shot DONE state is held.

Function
REQ-018 The block SHALL hold an internal prescaler pre_cnt (prescale_size bits) that increments on each enabled cycle and holds while enable=0.
REQ-019 A tick SHALL occur on an enabled cycle where pre_cnt == prescale; pre_cnt SHALL return to 0 on that cycle, so prescale=0 gives a tick on every enabled cycle.
REQ-020 Where load=1, the block SHALL set cnt_out to cnt_in, set pre_cnt to 0, go to RUN and generate no tick, regardless of enable or state; load SHALL have priority over a tick.
REQ-021 On an up tick with cnt_out < limit, cnt_out SHALL become cnt_out+1.
REQ-022 On an up tick with cnt_out >= limit (up terminal event), cnt_out SHALL become 0 in wrap mode and limit in saturate or one-shot mode.
REQ-023 On a down tick with cnt_out != 0, cnt_out SHALL become cnt_out-1, including when cnt_out > limit.
REQ-024 On a down tick with cnt_out == 0 (down terminal event), cnt_out SHALL become limit in wrap mode and stay 0 in saturate or one-shot mode.
REQ-025 The block SHALL implement a state machine with states RUN and DONE.
REQ-026 On a terminal event in one-shot mode, the block SHALL move RUN to DONE.
REQ-027 In DONE, the block SHALL ignore ticks, hold cnt_out and pre_cnt, and drive done=1.
REQ-028 The block SHALL leave DONE only on load or reset, independent of any later change of mode.
REQ-029 tc SHALL be 1 for exactly the one cycle after the edge on which a terminal event occurs, in every mode, including repeated saturate terminal events.
REQ-030 A terminal event SHALL set overflow (up) or underflow (down) on the same edge that sets tc.
REQ-031 Each flag SHALL clear on clear_flags=1; when a set and a clear occur on the same cycle, the set SHALL win.
REQ-032 With limit=0 and an up tick, cnt_out SHALL stay 0 and a terminal event SHALL occur on every tick.
REQ-033 A change of up_down, mode or limit SHALL take effect on the next tick, with no reset of pre_cnt.

Reset
REQ-034 While res_n=0, the block SHALL immediately, without waiting for clk, set cnt_out=0, pre_cnt=0, tc=0, overflow=0, underflow=0, done=0 and state=RUN.
REQ-035 Reset release SHALL be synchronised to clk by the integrator; the block SHALL count from the first rising edge with res_n=1.
REQ-036 An assertion of res_n mid-count or while in DONE SHALL abort the operation with no residual flag or pulse.

Verification
REQ-037 Wrap up: counter_size=8, limit=5, prescale=0, mode=00, up, enable=1 -> cnt_out 0,1,2,3,4,5,0; tc pulses once after 5->0; overflow=1.
REQ-038 Prescale/down: prescale=2, limit=3, down, from load 1 -> cnt_out changes every 3 enabled cycles 1,0,3; underflow=1; enable=0 for 4 cycles freezes cnt_out and pre_cnt.
REQ-039 Saturate: mode=01, up, limit=200, load 198 -> 199,200,200,200; tc pulses on each tick at 200; overflow stays 1 until clear_flags.
REQ-040 One-shot: mode=10, down, load 2 -> 1,0 then done=1 and cnt_out=0 held with enable=1; load 7 with enable=1 -> done=0 and cnt_out=7, then 6 on the next tick.
REQ-041 Priority: load=1 and tick on the same cycle -> cnt_out=cnt_in and no tc; clear_flags on the same cycle as an overflow event -> overflow=1.
REQ-042 Async reset: assert res_n=0 between clk edges while cnt_out=0x7F and done=1 -> all outputs 0 before the next edge; counting resumes from 0 after release.
